// File: rtl/fifo_rd_sync_ctrl.sv
// fifo_rd_sync_ctrl: read-domain async FIFO controller with parametrised gray pointer synchroniser
module fifo_rd_sync_ctrl #(
  parameter int ADDR_WIDTH  = 5,
  parameter int SYNC_STAGES = 3,
  parameter int AE_THRESH   = 2
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  input  logic                  rd_en,
  input  logic                  clr_underflow,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE = PW'(AE_THRESH);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 6) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..6");
  end
  if (AE_THRESH < 0 || AE_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_ae
    $error("AE_THRESH must be in 0..2**ADDR_WIDTH");
  end
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] sync_out, wbin, rbin_q, rbin_d, gray_q, gray_d, cnt_q, cnt_d;
  logic rd_acc, valid_q, valid_d, empty_q, empty_d, ae_q, ae_d, under_q, under_d;
  assign sync_out = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d[0] = wr_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    for (int i = 0; i < PW; i++) wbin[i] = ^(sync_out >> i);
    rd_acc  = rd_en & ~empty_q;
    rbin_d  = rbin_q + PW'(rd_acc);
    gray_d  = rbin_d ^ (rbin_d >> 1);
    empty_d = gray_d == sync_out;
    cnt_d   = wbin - rbin_d;
    ae_d    = cnt_d <= AE;
    valid_d = rd_acc;
    // a fresh underflow outranks a simultaneous clear
    under_d = (rd_en & empty_q) | (under_q & ~clr_underflow);
  end
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      sync_q  <= '{default: '0};
      rbin_q  <= '0;
      gray_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      under_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      rbin_q  <= rbin_d;
      gray_q  <= gray_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      under_q <= under_d;
    end
  end
  assign rd_addr      = rbin_q[ADDR_WIDTH-1:0];
  assign rd_ptr_gray  = gray_q;
  assign rd_valid     = valid_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign rd_count     = cnt_q;
  assign underflow    = under_q;
endmodule

// File: tb/tb_fifo_rd_sync_ctrl.sv
// tb_fifo_rd_sync_ctrl: scenario tasks plus a read-address scoreboard for fifo_rd_sync_ctrl
module tb_fifo_rd_sync_ctrl;
  localparam int AW = 4;
  localparam int SS = 3;
  localparam int AE = 2;
  logic r_clk = 1'b0, r_rst = 1'b1, rd_en = 1'b0, clr_underflow = 1'b0;
  logic [AW:0] wr_ptr_gray = '0;
  logic [AW-1:0] rd_addr;
  logic [AW:0] rd_ptr_gray, rd_count;
  logic rd_valid, empty, almost_empty, underflow;
  int errors = 0, checks = 0, wbin_m = 0, rbin_m = 0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] addr_prev = '0, mon_e;

  fifo_rd_sync_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SS), .AE_THRESH(AE)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .wr_ptr_gray(wr_ptr_gray), .rd_en(rd_en),
    .clr_underflow(clr_underflow), .rd_addr(rd_addr), .rd_ptr_gray(rd_ptr_gray),
    .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty),
    .rd_count(rd_count), .underflow(underflow)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [AW:0] g(int b);
    logic [AW:0] x;
    x = b[AW:0];
    return x ^ (x >> 1);
  endfunction

  // rd_valid pops the address that was presented during the accepting cycle
  always @(negedge r_clk) begin
    if (rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_valid_unexpected: rd_valid=1 at addr %0d, expected no read", addr_prev);
      end else begin
        mon_e = exp_q.pop_front();
        if (addr_prev !== mon_e) begin
          errors++;
          $display("FAIL rd_valid_addr: got %0d expected %0d", addr_prev, mon_e);
        end
      end
    end
    addr_prev = rd_addr;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic write_to(input int target);
    while (wbin_m != target) begin
      wbin_m = (wbin_m + 1) % 32;
      wr_ptr_gray = g(wbin_m);
      @(negedge r_clk);
    end
    repeat (SS + 1) @(negedge r_clk);
  endtask

  task automatic read_n(input int n);
    int cnt;
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      exp_q.push_back(AW'(rbin_m));
      rbin_m = (rbin_m + 1) % 32;
      @(negedge r_clk);
      cnt = (wbin_m - rbin_m + 32) % 32;
      checks += 6;
      if (rd_valid !== 1'b1) begin errors++; $display("FAIL read_valid: got %b expected 1", rd_valid); end
      if (rd_count !== (AW+1)'(cnt)) begin errors++; $display("FAIL read_count: got %0d expected %0d", rd_count, cnt); end
      if (empty !== (cnt == 0)) begin errors++; $display("FAIL read_empty: got %b expected %b", empty, cnt == 0); end
      if (almost_empty !== (cnt <= AE)) begin errors++; $display("FAIL read_ae: got %b expected %b", almost_empty, cnt <= AE); end
      if (rd_addr !== AW'(rbin_m)) begin errors++; $display("FAIL read_addr: got %0d expected %0d", rd_addr, rbin_m % 16); end
      if (rd_ptr_gray !== g(rbin_m)) begin errors++; $display("FAIL read_gray: got %h expected %h", rd_ptr_gray, g(rbin_m)); end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge r_clk);
    checks += 5;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
    if (rd_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rd_count); end
    if (rd_ptr_gray !== '0 || rd_addr !== '0) begin errors++; $display("FAIL reset_ptr: got %h/%0d expected 0/0", rd_ptr_gray, rd_addr); end
    if (rd_valid !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b/%b expected 0/0", rd_valid, underflow); end
    @(negedge r_clk);
    r_rst = 1'b0;
  endtask

  task automatic test_latency;
    wbin_m = 1;
    wr_ptr_gray = g(1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge r_clk);
      checks += 2;
      if (empty !== (i < 4)) begin errors++; $display("FAIL latency_empty_%0d: got %b expected %b", i, empty, i < 4); end
      if (rd_count !== ((i < 4) ? 5'd0 : 5'd1)) begin errors++; $display("FAIL latency_count_%0d: got %0d expected %0d", i, rd_count, (i < 4) ? 0 : 1); end
    end
  endtask

  task automatic test_drain;
    write_to(5);
    checks += 2;
    if (rd_count !== 5'd5) begin errors++; $display("FAIL drain_start_count: got %0d expected 5", rd_count); end
    if (empty !== 1'b0 || almost_empty !== 1'b0) begin errors++; $display("FAIL drain_start_flags: got %b/%b expected 0/0", empty, almost_empty); end
    read_n(5);
    @(negedge r_clk);
    checks += 2;
    if (rd_addr !== 4'd5) begin errors++; $display("FAIL drain_addr_hold: got %0d expected 5", rd_addr); end
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_idle: got %b expected 0", rd_valid); end
  endtask

  task automatic test_underflow;
    rd_en = 1'b1;
    @(negedge r_clk);
    checks += 3;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", underflow); end
    if (rd_addr !== 4'd5) begin errors++; $display("FAIL uf_addr: got %0d expected 5", rd_addr); end
    if (rd_valid !== 1'b0) begin errors++; $display("FAIL uf_valid: got %b expected 0", rd_valid); end
    clr_underflow = 1'b1;
    @(negedge r_clk);
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %b expected 1", underflow); end
    rd_en = 1'b0;
    @(negedge r_clk);
    checks++;
    if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", underflow); end
    clr_underflow = 1'b0;
  endtask

  task automatic test_wrap;
    write_to(31);
    read_n(26);
    checks++;
    if (rd_ptr_gray !== 5'h10) begin errors++; $display("FAIL wrap_gray31: got %h expected 10", rd_ptr_gray); end
    write_to(1);
    checks++;
    if (rd_count !== 5'd2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", rd_count); end
    read_n(2);
    checks += 2;
    if (rd_ptr_gray !== 5'h01) begin errors++; $display("FAIL wrap_gray1: got %h expected 01", rd_ptr_gray); end
    if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid;
    write_to(6);
    checks++;
    if (rd_count !== 5'd5) begin errors++; $display("FAIL mid_pre_count: got %0d expected 5", rd_count); end
    #2 r_rst = 1'b1;
    #1;
    checks += 4;
    if (empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL mid_flags: got %b/%b expected 1/1", empty, almost_empty); end
    if (rd_count !== '0) begin errors++; $display("FAIL mid_count: got %0d expected 0", rd_count); end
    if (rd_ptr_gray !== '0 || rd_addr !== '0) begin errors++; $display("FAIL mid_ptr: got %h/%0d expected 0/0", rd_ptr_gray, rd_addr); end
    if (underflow !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_uf_valid: got %b/%b expected 0/0", underflow, rd_valid); end
    wbin_m = 0;
    rbin_m = 0;
    wr_ptr_gray = '0;
    repeat (2) @(negedge r_clk);
    r_rst = 1'b0;
  endtask

  task automatic test_full;
    write_to(16);
    checks += 2;
    if (rd_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", rd_count); end
    if (empty !== 1'b0 || almost_empty !== 1'b0) begin errors++; $display("FAIL full_flags: got %b/%b expected 0/0", empty, almost_empty); end
    read_n(14);
    checks++;
    if (almost_empty !== 1'b1) begin errors++; $display("FAIL full_ae_at2: got %b expected 1", almost_empty); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_drain;
    test_underflow;
    test_wrap;
    test_reset_mid;
    test_full;
    repeat (2) @(negedge r_clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending reads expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
